mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Moore-style control unit for the multicycle MIPS core. It sequences a single shared byte-addressed memory and the 3-bit-encoded ALU through fetch, decode, execute, memory and writeback states. Each cycle it drives the datapath mux selects, the write enables and the ALU operation code. It also keeps a retired-instruction counter for the testbench and performance checks.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces FETCH, clears counter
- opcode  in  6  instruction register bits [31:26]
- funct  in  6  instruction register bits [5:0]
- zero  in  1  ALU zero flag
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register load
- reg_dst  out  1  register write address: 0 = rt, 1 = rd
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  SrcA select: 0 = PC, 1 = register A
- alu_src_b  out  2  SrcB select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_control  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load = pc_write | (branch & zero)
- state  out  4  current state encoding (debug)
- illegal_op  out  1  one-cycle pulse on an unsupported opcode in DECODE
- retired  out  1  one-cycle pulse in the final cycle of each instruction
- instr_count  out  32  count of retired instructions

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Codes 12–15 return to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR for lw/sw; EXECUTE for R-type; BRANCH for beq; ADDIEXEC for addi; JUMP for j; FETCH for anything else, with illegal_op = 1.
  - MEMADR → MEMRD for lw; MEMWR for sw.
  - MEMRD → MEMWB.
  - EXECUTE → ALUWB.
  - ADDIEXEC → ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP → FETCH.
- Outputs are a function of state only, except alu_control in EXECUTE (from funct) and pc_en in BRANCH (from zero). Any output not listed for a state is 0.
  - FETCH: alu_src_b = 01, alu_control = 010, ir_write = 1, pc_write = 1.
  - DECODE: alu_src_b = 11, alu_control = 010.
  - MEMADR: alu_src_a = 1, alu_src_b = 10, alu_control = 010.
  - MEMRD: iord = 1.
  - MEMWB: mem_to_reg = 1, reg_write = 1.
  - MEMWR: iord = 1, mem_write = 1.
  - EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_control from funct.
  - ALUWB: reg_dst = 1, reg_write = 1.
  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_control = 110, pc_src = 01, branch = 1.
  - ADDIEXEC: alu_src_a = 1, alu_src_b = 10, alu_control = 010.
  - ADDIWB: reg_write = 1.
  - JUMP: pc_src = 10, pc_write = 1.
- Funct decode in EXECUTE:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - any other funct → 010; this is not flagged as illegal.
- Retirement:
  - retired = 1 in MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP.
  - instr_count increments by 1 on each rising edge where retired = 1. It wraps from 0xFFFFFFFF to 0.
  - An illegal opcode does not retire and does not increment the counter.

## Timing
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset behaviour:
  - Asynchronous assertion sets state = FETCH and instr_count = 0.
  - While reset is high, mem_write, ir_write, reg_write, pc_en, illegal_op and retired are forced to 0. Other outputs show the FETCH values.
  - The first rising edge after release is the first FETCH cycle.
- Reset asserted mid-instruction aborts the instruction: no further strobes, and the counter is cleared.
- opcode and funct are sampled only in DECODE, EXECUTE and MEMADR. They are stable because ir_write is 0 outside FETCH.
- mem_write stays high for the whole MEMWR cycle; the memory commits on that cycle's falling edge.
- In BRANCH, pc_en equals zero combinationally within the same cycle.
- illegal_op and retired are never high in the same cycle.

## Test plan
- Reset: hold reset for 3 cycles, then release → state = 0, instr_count = 0, all enables 0 during reset. The first cycle after release shows ir_write = 1 and pc_en = 1.
- lw (opcode 100011): states 0 → 1 → 2 → 3 → 4 → 0 over 5 cycles. MEMRD has iord = 1. MEMWB has reg_write = 1 and mem_to_reg = 1. instr_count goes 0 → 1.
- sw then addi: MEMWR has mem_write = 1 and iord = 1. ADDIWB has reg_write = 1 and reg_dst = 0. After 8 cycles instr_count = 2.
- R-type with funct 100010, 101010, 100101 and 111111 → EXECUTE alu_control = 110, 111, 001 and 010 respectively. ALUWB has reg_dst = 1.
- beq with zero = 1, then with zero = 0 → BRANCH pc_en = 1 with pc_src = 01, then pc_en = 0. Each takes 3 cycles and retires.
- Illegal opcode 111111 → illegal_op pulses in DECODE, next state is FETCH, instr_count unchanged. Separately, assert reset in MEMRD of a lw → state = 0 immediately and instr_count = 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: instruction fields and zero flag in, datapath controls out
interface mips_multicycle_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        iord;
  logic        mem_write;
  logic        ir_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_control;
  logic [1:0]  pc_src;
  logic        pc_en;
  logic [3:0]  state;
  logic        illegal_op;
  logic        retired;
  logic [31:0] instr_count;
  modport master (
    input  opcode, funct, zero,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, alu_control, pc_src, pc_en, state, illegal_op, retired, instr_count
  );
  modport slave (
    output opcode, funct, zero,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, alu_control, pc_src, pc_en, state, illegal_op, retired, instr_count
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM for the multicycle MIPS core with retired-instruction counter
module mips_multicycle_ctrl (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEXEC = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
  } state_t;
  state_t      r_state, w_next;
  logic [31:0] r_count;
  logic        w_iord, w_mem_write, w_ir_write, w_reg_dst, w_mem_to_reg, w_reg_write;
  logic        w_alu_src_a, w_pc_write, w_branch, w_illegal, w_retired;
  logic [1:0]  w_alu_src_b, w_pc_src;
  logic [2:0]  w_alu_control, w_funct_alu;
  assign w_funct_alu = (bus.funct == 6'b100010) ? 3'b110 :
                       (bus.funct == 6'b100100) ? 3'b000 :
                       (bus.funct == 6'b100101) ? 3'b001 :
                       (bus.funct == 6'b101010) ? 3'b111 : 3'b010;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_count <= r_count + {31'b0, w_retired};
    end
  always_comb begin
    w_next = FETCH;
    w_iord = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write = 1'b0;
    w_reg_dst = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write = 1'b0;
    w_alu_src_a = 1'b0;
    w_alu_src_b = 2'b00;
    w_alu_control = 3'b000;
    w_pc_src = 2'b00;
    w_pc_write = 1'b0;
    w_branch = 1'b0;
    w_illegal = 1'b0;
    w_retired = 1'b0;
    case (r_state)
      FETCH: begin
        w_next = DECODE;
        w_alu_src_b = 2'b01;
        w_alu_control = 3'b010;
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
      end
      DECODE: begin
        w_alu_src_b = 2'b11;
        w_alu_control = 3'b010;
        case (bus.opcode)
          6'b100011, 6'b101011: w_next = MEMADR;
          6'b000000:            w_next = EXECUTE;
          6'b000100:            w_next = BRANCH;
          6'b001000:            w_next = ADDIEXEC;
          6'b000010:            w_next = JUMP;
          default:              w_illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        w_next = (bus.opcode == 6'b101011) ? MEMWR : MEMRD;
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_control = 3'b010;
      end
      MEMRD: begin
        w_next = MEMWB;
        w_iord = 1'b1;
      end
      MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write = 1'b1;
        w_retired = 1'b1;
      end
      MEMWR: begin
        w_iord = 1'b1;
        w_mem_write = 1'b1;
        w_retired = 1'b1;
      end
      EXECUTE: begin
        w_next = ALUWB;
        w_alu_src_a = 1'b1;
        w_alu_control = w_funct_alu;
      end
      ALUWB: begin
        w_reg_dst = 1'b1;
        w_reg_write = 1'b1;
        w_retired = 1'b1;
      end
      BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_control = 3'b110;
        w_pc_src = 2'b01;
        w_branch = 1'b1;
        w_retired = 1'b1;
      end
      ADDIEXEC: begin
        w_next = ADDIWB;
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_control = 3'b010;
      end
      ADDIWB: begin
        w_reg_write = 1'b1;
        w_retired = 1'b1;
      end
      JUMP: begin
        w_pc_src = 2'b10;
        w_pc_write = 1'b1;
        w_retired = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end
  // strobes are masked while reset is held; selects keep showing the FETCH values
  assign bus.mem_write   = w_mem_write & ~reset;
  assign bus.ir_write    = w_ir_write & ~reset;
  assign bus.reg_write   = w_reg_write & ~reset;
  assign bus.pc_en       = (w_pc_write | (w_branch & bus.zero)) & ~reset;
  assign bus.illegal_op  = w_illegal & ~reset;
  assign bus.retired     = w_retired & ~reset;
  assign bus.iord        = w_iord;
  assign bus.reg_dst     = w_reg_dst;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.alu_control = w_alu_control;
  assign bus.pc_src      = w_pc_src;
  assign bus.state       = r_state;
  assign bus.instr_count = r_count;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed and random instruction streams checked against a per-instruction reference model
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fails = 0;
  logic [31:0] exp_count = 0;
  mips_multicycle_ctrl_if bus ();
  mips_multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic supported(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Visited states for one instruction, straight from the instruction class
  function automatic void path_of(input logic [5:0] op, output int p[$]);
    case (op)
      6'b100011: p = '{0, 1, 2, 3, 4};
      6'b101011: p = '{0, 1, 2, 5};
      6'b000000: p = '{0, 1, 6, 7};
      6'b001000: p = '{0, 1, 9, 10};
      6'b000100: p = '{0, 1, 8};
      6'b000010: p = '{0, 1, 11};
      default:   p = '{0, 1};
    endcase
  endfunction

  // Expected control word per state: each signal from the set of states that assert it
  function automatic logic [16:0] exp_word(input int s, input logic [5:0] op, input logic [5:0] f, input logic z);
    logic [1:0] b;
    logic [2:0] a;
    logic [1:0] ps;
    b  = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : (s inside {2, 9}) ? 2'b10 : 2'b00;
    a  = (s == 6) ? funct_alu(f) : (s == 8) ? 3'b110 : (s inside {0, 1, 2, 9}) ? 3'b010 : 3'b000;
    ps = (s == 8) ? 2'b01 : (s == 11) ? 2'b10 : 2'b00;
    return {s inside {3, 5}, s == 5, s == 0, s == 7, s == 4, s inside {4, 7, 10},
            s inside {2, 6, 8, 9}, b, a, ps, (s inside {0, 11}) || (s == 8 && z),
            s == 1 && !supported(op), s inside {4, 5, 7, 8, 10, 11}};
  endfunction

  function automatic logic [16:0] dut_word();
    return {bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.pc_src, bus.pc_en,
            bus.illegal_op, bus.retired};
  endfunction

  // Called mid-cycle with state = FETCH; returns mid-cycle after the last executed step
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] f, input logic z, input int max_steps);
    int p[$];
    path_of(op, p);
    for (int i = 0; i < p.size() && i < max_steps; i++) begin
      bus.opcode = op;
      bus.funct  = f;
      bus.zero   = z;
      #1;
      check({tag, "_state"}, {28'b0, bus.state}, p[i]);
      check({tag, "_ctrl"}, {15'b0, dut_word()}, {15'b0, exp_word(p[i], op, f, z)});
      check({tag, "_count"}, bus.instr_count, exp_count);
      if (p[i] inside {4, 5, 7, 8, 10, 11}) exp_count++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, {28'b0, bus.state}, 0);
    check({tag, "_count"}, bus.instr_count, 0);
    check({tag, "_strobes"}, {26'b0, bus.mem_write, bus.ir_write, bus.reg_write, bus.pc_en, bus.illegal_op, bus.retired}, 0);
    check({tag, "_sel"}, {27'b0, bus.alu_src_b, bus.alu_control}, {27'b0, 2'b01, 3'b010});
  endtask

  initial begin
    logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] rfun [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011011};
    logic [5:0] op;
    bus.opcode = 6'b0;
    bus.funct  = 6'b0;
    bus.zero   = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset("rst");
    end
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    run_instr("lw", 6'b100011, 6'b0, 1'b0, 99);
    run_instr("sw", 6'b101011, 6'b0, 1'b0, 99);
    run_instr("addi", 6'b001000, 6'b0, 1'b0, 99);
    run_instr("r_sub", 6'b000000, 6'b100010, 1'b0, 99);
    run_instr("r_slt", 6'b000000, 6'b101010, 1'b0, 99);
    run_instr("r_or", 6'b000000, 6'b100101, 1'b0, 99);
    run_instr("r_dflt", 6'b000000, 6'b111111, 1'b0, 99);
    run_instr("beq_t", 6'b000100, 6'b0, 1'b1, 99);
    run_instr("beq_n", 6'b000100, 6'b0, 1'b0, 99);
    run_instr("illegal", 6'b111111, 6'b0, 1'b0, 99);
    run_instr("j", 6'b000010, 6'b0, 1'b0, 99);
    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      run_instr("rand", op, rfun[$urandom_range(0, 5)], 1'($urandom), 99);
    end
    run_instr("lw_abort", 6'b100011, 6'b0, 1'b0, 3);
    check("abort_in_memrd", {28'b0, bus.state}, 3);
    reset = 1'b1;
    exp_count = 0;
    #1;
    check_reset("abort");
    @(posedge clk);
    #1;
    check_reset("abort_hold");
    @(negedge clk);
    reset = 1'b0;
    run_instr("j_after", 6'b000010, 6'b0, 1'b0, 99);
    check("final_count", bus.instr_count, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
